strobe_merge: RTL and testbench

STROBE_MERGE -- requirements
Module: strobe_merge

---
 rtl/strobe_merge_pkg.sv | 26 ++
 rtl/strobe_merge_rr_arb.sv | 37 +++
 rtl/strobe_merge.sv | 147 ++++++++++++++
 tb/tb_strobe_merge.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/strobe_merge_pkg.sv
// -----------------------------------------------------------------------------
// strobe_merge_pkg
//   Shared constants and helpers for the strobe_merge block.
//   - N_CH_DEF / DEPTH_DEF : default channel count and per-channel pending depth
//   - DROP_W               : width of the saturating drop counter
//   - DROP_INC_W           : width of a per-cycle drop increment (up to 16 drops)
//   - sat_add()            : saturating add of a small increment to a DROP_W value
// -----------------------------------------------------------------------------
package strobe_merge_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int DEPTH_DEF  = 7;
  localparam int DROP_W     = 16;
  localparam int DROP_INC_W = 5;

  // Adds b to a, clamping at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_add(
    input logic [DROP_W-1:0]     a,
    input logic [DROP_INC_W-1:0] b
  );
    logic [DROP_W:0] s;
    s = {1'b0, a} + (DROP_W+1)'(b);
    sat_add = s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/strobe_merge_rr_arb.sv
// -----------------------------------------------------------------------------
// strobe_merge_rr_arb
//   Purely combinational round-robin search. The search starts at last+1
//   (mod N) and wraps, so the previously granted channel has lowest priority.
//   Ports:
//     req     [N]   : channels with pending events
//     last    [IW]  : index of the most recent grant
//     gnt_vld       : at least one request present
//     gnt_idx [IW]  : selected channel (0 when gnt_vld is low)
// -----------------------------------------------------------------------------
module strobe_merge_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    logic [IW-1:0] p;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    p       = '0;
    // k = 1..N visits last+1 .. last+N (the last one is 'last' itself);
    // the first hit wins.
    for (int k = 1; k <= N; k++) begin
      p = IW'((int'(last) + k) % N);
      if (!gnt_vld && req[p]) begin
        gnt_vld = 1'b1;
        gnt_idx = p;
      end
    end
  end

endmodule

// File: rtl/strobe_merge.sv
// -----------------------------------------------------------------------------
// strobe_merge
//   Merges N_CH one-cycle strobe channels into a single stallable strobe
//   stream. Each channel buffers up to DEPTH pending events in a counter; a
//   round-robin arbiter moves one event per cycle into a one-entry output
//   register. Strobes arriving at a full channel are dropped and counted.
//
//   Optional feature (macro STROBE_MERGE_CHID_EN): adds output out_chid with
//   the channel index of the presented entry.
//
//   Ports:
//     dest_clk      : clock, rising edge
//     dest_reset_n  : asynchronous active-low reset
//     in_strobe[N]  : per-channel event pulse
//     in_stall[N]   : channel full; a strobe this cycle is refused
//     out_strobe    : merged event presented
//     out_stall     : downstream refuses the presented event
//     drop_count    : saturating count of refused strobes
//     out_chid      : (STROBE_MERGE_CHID_EN only) source channel of the entry
// -----------------------------------------------------------------------------
module strobe_merge
  import strobe_merge_pkg::*;
#(
  parameter  int N_CH  = N_CH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic              dest_clk,
  input  logic              dest_reset_n,
  input  logic [N_CH-1:0]   in_strobe,
  output logic [N_CH-1:0]   in_stall,
  output logic              out_strobe,
  input  logic              out_stall,
  output logic [DROP_W-1:0] drop_count
`ifdef STROBE_MERGE_CHID_EN
  ,
  output logic [CH_W-1:0]   out_chid
`endif
);

  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [DROP_W-1:0]          drop_count_q, drop_count_d;
  logic                       out_vld_q, out_vld_d;
  logic [CH_W-1:0]            last_grant_q, last_grant_d;

  logic [N_CH-1:0]            req, acc, drop;
  logic                       xfer, load_ok, grant;
  logic                       gnt_vld;
  logic [CH_W-1:0]            gnt_idx;
  logic [DROP_INC_W-1:0]      n_drop;

  // Full flag comes straight from the registered counter so upstream sees no
  // combinational path; a grant in the same cycle does not free the slot yet.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      in_stall[i] = (cnt_q[i] == CNT_W'(DEPTH));
      req[i]      = (cnt_q[i] != '0);
    end
  end

  assign acc  = in_strobe & ~in_stall;
  assign drop = in_strobe &  in_stall;

  assign out_strobe = out_vld_q;
  assign drop_count = drop_count_q;

  // The entry can take a new event when empty or when it leaves this cycle.
  assign xfer    = out_vld_q && !out_stall;
  assign load_ok = !out_vld_q || xfer;

  strobe_merge_rr_arb #(.N(N_CH)) u_arb (
    .req     (req),
    .last    (last_grant_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign grant = gnt_vld && load_ok;

  // Per-channel counters: accept and grant together cancel out.
  always_comb begin
    logic gi;
    cnt_d = cnt_q;
    gi    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      gi = grant && (gnt_idx == CH_W'(i));
      if (acc[i] && !gi)
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (!acc[i] && gi)
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  // Drops from several channels in one cycle are summed before the add.
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_CH; i++)
      n_drop = n_drop + DROP_INC_W'(drop[i]);
    drop_count_d = sat_add(drop_count_q, n_drop);
  end

  // Output entry: reloads only when free; otherwise held while stalled.
  always_comb begin
    out_vld_d    = out_vld_q;
    last_grant_d = last_grant_q;
    if (load_ok)
      out_vld_d = grant;
    if (grant)
      last_grant_d = gnt_idx;
  end

  always_ff @(posedge dest_clk or negedge dest_reset_n) begin
    if (!dest_reset_n) begin
      cnt_q        <= '0;
      drop_count_q <= '0;
      out_vld_q    <= 1'b0;
      last_grant_q <= CH_W'(N_CH-1);
    end else begin
      cnt_q        <= cnt_d;
      drop_count_q <= drop_count_d;
      out_vld_q    <= out_vld_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef STROBE_MERGE_CHID_EN
  logic [CH_W-1:0] out_chid_q, out_chid_d;

  // Loads together with the entry, so it is held while out_stall is high.
  always_comb begin
    out_chid_d = out_chid_q;
    if (grant)
      out_chid_d = gnt_idx;
  end

  always_ff @(posedge dest_clk or negedge dest_reset_n) begin
    if (!dest_reset_n)
      out_chid_q <= '0;
    else
      out_chid_q <= out_chid_d;
  end

  assign out_chid = out_chid_q;
`endif

endmodule

// File: tb/tb_strobe_merge.sv
// -----------------------------------------------------------------------------
// tb_strobe_merge
//   Self-checking bench for strobe_merge (N_CH=4, DEPTH=7). Expected output
//   events (cycle of transfer, source channel) are queued when stimulus is
//   driven and compared by a monitor at every observed transfer.
// -----------------------------------------------------------------------------
module tb_strobe_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_strobe;
  logic [3:0]  in_stall;
  logic        out_strobe;
  logic        out_stall;
  logic [15:0] drop_count;
`ifdef STROBE_MERGE_CHID_EN
  logic [1:0]  out_chid;
`endif

  strobe_merge #(.N_CH(4), .DEPTH(7)) dut (
    .dest_clk     (clk),
    .dest_reset_n (rst_n),
    .in_strobe    (in_strobe),
    .in_stall     (in_stall),
    .out_strobe   (out_strobe),
    .out_stall    (out_stall),
    .drop_count   (drop_count)
`ifdef STROBE_MERGE_CHID_EN
    ,
    .out_chid     (out_chid)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ch;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // Samples transfers on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_strobe === 1'b1 && out_stall === 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", cyc, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_cycle", cyc, e.cyc);
`ifdef STROBE_MERGE_CHID_EN
        chk("out_chid", out_chid, e.ch);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c, d, g, r;
    rst_n     = 1'b0;
    in_strobe = '0;
    out_stall = 1'b0;
    step();
    step();
    chk("rst_out_strobe", out_strobe, 0);
    chk("rst_in_stall",   in_stall,   0);
    chk("rst_drop",       drop_count, 0);
    rst_n = 1'b1;
    step();

    // single strobe on ch2: out_strobe exactly in cycle +2
    c = cyc;
    in_strobe = 4'b0100;
    sb.push_back('{c+2, 2});
    step();
    in_strobe = '0;
    chk("t1_lat1", out_strobe, 0);
    step();
    chk("t1_lat2", out_strobe, 1);
    step();
    chk("t1_lat3", out_strobe, 0);
    chk("t1_drop", drop_count, 0);

    // fill ch0 while stalled: entry holds one, 7 pending, 8th dropped
    out_stall = 1'b1;
    in_strobe = 4'b0001;
    step();
    in_strobe = '0;
    step();
    chk("t2_entry", out_strobe, 1);
    d = cyc;
    for (int k = 0; k < 8; k++) begin
      chk("t2_in_stall0", in_stall[0], (k == 7));
      in_strobe = 4'b0001;
      step();
    end
    in_strobe = '0;
    chk("t2_drop",     drop_count, 1);
    chk("t2_held",     out_strobe, 1);
    chk("t2_stallvec", in_stall,   4'b0001);
    r = cyc;
    out_stall = 1'b0;
    for (int k = 0; k < 8; k++) sb.push_back('{r+k, 0});
    for (int k = 0; k < 8; k++) step();
    chk("t2_empty",    out_strobe, 0);
    chk("t2_unstall",  in_stall,   0);

    // three strobes on every channel: 12 back-to-back transfers 0,1,2,3,...
    do_reset();
    c = cyc;
    for (int k = 0; k < 12; k++) sb.push_back('{c+2+k, k % 4});
    for (int k = 0; k < 3; k++) begin
      in_strobe = 4'hF;
      step();
    end
    in_strobe = '0;
    while (cyc < c + 14) step();
    chk("t3_done", out_strobe, 0);
    chk("t3_drop", drop_count, 0);

    // ch1 full; strobe in its grant cycle refused, next accepted
    do_reset();
    out_stall = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_strobe = 4'b0010;
      step();
    end
    g = cyc;
    chk("t4_full",  in_stall,   4'b0010);
    chk("t4_drop0", drop_count, 0);
    out_stall = 1'b0;
    in_strobe = 4'b0010;
    for (int k = 0; k < 9; k++) sb.push_back('{g+k, 1});
    step();
    chk("t4_refused", drop_count, 1);
    chk("t4_freed",   in_stall,   0);
    in_strobe = 4'b0010;
    step();
    in_strobe = '0;
    chk("t4_accepted", drop_count, 1);
    while (cyc < g + 9) step();
    chk("t4_done", out_strobe, 0);

    // reset with 5 pending discards everything
    out_stall = 1'b1;
    in_strobe = 4'b0111;
    step();
    step();
    in_strobe = '0;
    chk("t5_busy", out_strobe, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out",   out_strobe, 0);
    chk("t5_rst_stall", in_stall,   0);
    step();
    rst_n     = 1'b1;
    out_stall = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("t5_quiet", out_strobe, 0);
    chk("t5_drop",  drop_count, 0);

    // saturation: fill all channels, drive drops up to FFFE, then +4
    out_stall = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_strobe = 4'hF;
      step();
    end
    chk("t6_fill_drop", drop_count, 3);
    chk("t6_all_full",  in_stall,   4'hF);
    for (int k = 0; k < 16382; k++) begin
      in_strobe = 4'hF;
      step();
    end
    chk("t6_mid", drop_count, 65531);
    in_strobe = 4'b0111;
    step();
    chk("t6_fffe", drop_count, 16'hFFFE);
    in_strobe = 4'hF;
    step();
    chk("t6_sat", drop_count, 16'hFFFF);
    step();
    chk("t6_sat_hold", drop_count, 16'hFFFF);
    in_strobe = '0;
    do_reset();
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
